// File: rtl/axi4_lite_ctrl_master.sv
`default_nettype none
// ============================================================================
// axi4_lite_ctrl_master : single-outstanding AXI4-Lite initiator driven by a
// simple cmd/rsp port. Optional AXI_MASTER_TIMEOUT_EN adds a wait-cycle limit.
// Revision 1.0
// ============================================================================
module axi4_lite_ctrl_master #(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         m_axi_ctrl_aclk,
  input  logic                         m_axi_ctrl_areset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]    cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         busy,
  output logic                         timeout_flag,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_araddr,
  output logic                         m_axi_ctrl_arvalid,
  input  logic                         m_axi_ctrl_arready,
  input  logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_rdata,
  input  logic [1:0]                   m_axi_ctrl_rresp,
  input  logic                         m_axi_ctrl_rvalid,
  output logic                         m_axi_ctrl_rready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_ctrl_awaddr,
  output logic                         m_axi_ctrl_awvalid,
  input  logic                         m_axi_ctrl_awready,
  output logic [AXI_DATA_WIDTH-1:0]    m_axi_ctrl_wdata,
  output logic                         m_axi_ctrl_wvalid,
  input  logic                         m_axi_ctrl_wready,
  input  logic [1:0]                   m_axi_ctrl_bresp,
  input  logic                         m_axi_ctrl_bvalid,
  output logic                         m_axi_ctrl_bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                       state, state_n;
  logic                         aw_done, aw_done_n, w_done, w_done_n;
  logic                         aw_fin, w_fin, abort, to_hit;
  logic                         awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic                         rsp_valid_n, timeout_flag_n;
  logic [AXI_ADDRESS_WIDTH-1:0] awaddr_n, araddr_n;
  logic [AXI_DATA_WIDTH-1:0]    wdata_n, rsp_rdata_n;
  logic [1:0]                   rsp_resp_n;

  // Gated by reset so no command is offered while the block is held in reset.
  assign cmd_ready = (state == IDLE) && !m_axi_ctrl_areset;
  assign busy      = (state != IDLE);

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge m_axi_ctrl_aclk or posedge m_axi_ctrl_areset) begin
    if (m_axi_ctrl_areset)                                  to_cnt <= '0;
    else if (state == IDLE)                                 to_cnt <= '0;
    else if (state != RSP && to_cnt != CNT_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (to_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_n        = state;
    aw_done_n      = aw_done;
    w_done_n       = w_done;
    awvalid_n      = m_axi_ctrl_awvalid;
    wvalid_n       = m_axi_ctrl_wvalid;
    bready_n       = m_axi_ctrl_bready;
    arvalid_n      = m_axi_ctrl_arvalid;
    rready_n       = m_axi_ctrl_rready;
    awaddr_n       = m_axi_ctrl_awaddr;
    araddr_n       = m_axi_ctrl_araddr;
    wdata_n        = m_axi_ctrl_wdata;
    rsp_valid_n    = rsp_valid;
    rsp_rdata_n    = rsp_rdata;
    rsp_resp_n     = rsp_resp;
    timeout_flag_n = timeout_flag;
    abort          = 1'b0;
    aw_fin         = aw_done | (m_axi_ctrl_awvalid & m_axi_ctrl_awready);
    w_fin          = w_done  | (m_axi_ctrl_wvalid  & m_axi_ctrl_wready);

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            state_n   = WR_REQ;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = cmd_addr;
            wdata_n   = cmd_wdata;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
          end else begin
            state_n   = RD_REQ;
            arvalid_n = 1'b1;
            araddr_n  = cmd_addr;
          end
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave only once both have completed.
        if (m_axi_ctrl_awvalid && m_axi_ctrl_awready) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (m_axi_ctrl_wvalid && m_axi_ctrl_wready) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (aw_fin && w_fin) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_ctrl_bvalid) begin
          state_n     = RSP;
          bready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = '0;
          rsp_resp_n  = m_axi_ctrl_bresp;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
      RD_REQ: begin
        if (m_axi_ctrl_arready) begin
          state_n   = RD_RESP;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
      RD_RESP: begin
        if (m_axi_ctrl_rvalid) begin
          state_n     = RSP;
          rready_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = m_axi_ctrl_rdata;
          rsp_resp_n  = m_axi_ctrl_rresp;
        end else if (to_hit) begin
          abort = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    // Debug recovery: abandon the bus transaction and report a synthetic error.
    if (abort) begin
      state_n        = RSP;
      awvalid_n      = 1'b0;
      wvalid_n       = 1'b0;
      bready_n       = 1'b0;
      arvalid_n      = 1'b0;
      rready_n       = 1'b0;
      rsp_valid_n    = 1'b1;
      rsp_rdata_n    = '0;
      rsp_resp_n     = 2'b11;
      timeout_flag_n = 1'b1;
    end
  end

  always_ff @(posedge m_axi_ctrl_aclk or posedge m_axi_ctrl_areset) begin
    if (m_axi_ctrl_areset) begin
      state              <= IDLE;
      aw_done            <= 1'b0;
      w_done             <= 1'b0;
      m_axi_ctrl_awvalid <= 1'b0;
      m_axi_ctrl_wvalid  <= 1'b0;
      m_axi_ctrl_bready  <= 1'b0;
      m_axi_ctrl_arvalid <= 1'b0;
      m_axi_ctrl_rready  <= 1'b0;
      m_axi_ctrl_awaddr  <= '0;
      m_axi_ctrl_araddr  <= '0;
      m_axi_ctrl_wdata   <= '0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= '0;
      rsp_resp           <= 2'b00;
      timeout_flag       <= 1'b0;
    end else begin
      state              <= state_n;
      aw_done            <= aw_done_n;
      w_done             <= w_done_n;
      m_axi_ctrl_awvalid <= awvalid_n;
      m_axi_ctrl_wvalid  <= wvalid_n;
      m_axi_ctrl_bready  <= bready_n;
      m_axi_ctrl_arvalid <= arvalid_n;
      m_axi_ctrl_rready  <= rready_n;
      m_axi_ctrl_awaddr  <= awaddr_n;
      m_axi_ctrl_araddr  <= araddr_n;
      m_axi_ctrl_wdata   <= wdata_n;
      rsp_valid          <= rsp_valid_n;
      rsp_rdata          <= rsp_rdata_n;
      rsp_resp           <= rsp_resp_n;
      timeout_flag       <= timeout_flag_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_ctrl_master.sv
`default_nettype none
// tb_axi4_lite_ctrl_master : directed commands against a scripted AXI4-Lite slave,
// a transaction-level response model and a per-cycle compare process.
module tb_axi4_lite_ctrl_master;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, busy, timeout_flag;
  logic [AW-1:0] cmd_addr, araddr, awaddr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, rdata, wdata;
  logic [1:0]    rsp_resp, rresp, bresp;
  logic          arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;

  axi4_lite_ctrl_master #(.AXI_ADDRESS_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .m_axi_ctrl_aclk(clk), .m_axi_ctrl_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .timeout_flag(timeout_flag),
    .m_axi_ctrl_araddr(araddr), .m_axi_ctrl_arvalid(arvalid), .m_axi_ctrl_arready(arready),
    .m_axi_ctrl_rdata(rdata), .m_axi_ctrl_rresp(rresp), .m_axi_ctrl_rvalid(rvalid),
    .m_axi_ctrl_rready(rready),
    .m_axi_ctrl_awaddr(awaddr), .m_axi_ctrl_awvalid(awvalid), .m_axi_ctrl_awready(awready),
    .m_axi_ctrl_wdata(wdata), .m_axi_ctrl_wvalid(wvalid), .m_axi_ctrl_wready(wready),
    .m_axi_ctrl_bresp(bresp), .m_axi_ctrl_bvalid(bvalid), .m_axi_ctrl_bready(bready)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Slave behaviour knobs
  int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0;
  bit          cfg_b_never = 0, cfg_ar_never = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;

  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt;
    bit aw_got, w_got, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      ar_hs = arvalid && arready; r_hs = rvalid && rready;
      @(posedge clk); #1;
      if (rst) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_got = 0; w_got = 0;
      end else begin
        if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
        if (w_hs)  begin w_got = 1;  w_cnt = 0;  end
        if (b_hs) begin
          bvalid = 0; aw_got = 0; w_got = 0;
        end else if (aw_got && w_got && !bvalid && !cfg_b_never) begin
          bvalid = 1; bresp = cfg_bresp;
        end
        if (r_hs) rvalid = 0;
        if (ar_hs) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; ar_cnt = 0; end
        awready = awvalid && !aw_got && (aw_cnt == cfg_aw_delay);
        if (awvalid && !aw_got && !awready) aw_cnt++;
        wready = wvalid && !w_got && (w_cnt == cfg_w_delay);
        if (wvalid && !w_got && !wready) w_cnt++;
        arready = arvalid && !cfg_ar_never && (ar_cnt == cfg_ar_delay);
        if (arvalid && !arready) ar_cnt++;
      end
    end
  end

  // Transaction-level model: each accepted command predicts exactly one response.
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    bit            to;
  } txn_t;
  txn_t q[$];
  txn_t cur;
  bit   outstanding = 0, exp_to = 0;
  int   aw_cyc, w_cyc, ar_cyc, rv_cyc, last_rv_cyc, n_b_hs = 0;
  int   t_accept, t_ar_rise, t_rsp_rise, t_rsp_hs;
  logic [DW-1:0] last_rdata;
  logic [1:0]    last_resp;

  initial begin : compare
    logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr, p_rv, p_rr;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic [1:0]    p_resp;
    txn_t e, n;
    p_aw = 0; p_awr = 0; p_w = 0; p_wr = 0; p_ar = 0; p_arr = 0; p_rv = 0; p_rr = 0;
    p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_rdata = '0; p_resp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_ctrl", {cmd_ready, busy, rsp_valid, awvalid, wvalid, bready,
                           arvalid, rready, timeout_flag}, 64'd0);
        chk("reset_data", {63'd0, |{awaddr, araddr, wdata, rsp_rdata, rsp_resp}}, 64'd0);
        q.delete(); outstanding = 0; exp_to = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_rv = 0;
        continue;
      end
      if (rsp_valid && !p_rv) begin
        t_rsp_rise = cyc;
        if (q.size() > 0 && q[0].to) exp_to = 1;
      end
      if (arvalid && !p_ar) t_ar_rise = cyc;
      chk("cmd_ready", cmd_ready, !outstanding);
      chk("busy", busy, outstanding);
      chk("timeout_flag", timeout_flag, exp_to);
      if (!outstanding) chk("rsp_valid_idle", rsp_valid, 0);
      if (p_aw && !p_awr) begin chk("awvalid_hold", awvalid, 1); chk("awaddr_hold", awaddr, p_awaddr); end
      if (p_w && !p_wr)   begin chk("wvalid_hold", wvalid, 1);   chk("wdata_hold", wdata, p_wdata);     end
      if (p_ar && !p_arr) begin chk("arvalid_hold", arvalid, 1); chk("araddr_hold", araddr, p_araddr); end
      if (p_rv && !p_rr) begin
        chk("rsp_valid_hold", rsp_valid, 1);
        chk("rsp_rdata_hold", rsp_rdata, p_rdata);
        chk("rsp_resp_hold", rsp_resp, p_resp);
      end
      if (awvalid) aw_cyc++;
      if (wvalid)  w_cyc++;
      if (arvalid) ar_cyc++;
      if (rsp_valid) rv_cyc++;
      if (awvalid && awready) chk("aw_addr", awaddr, cur.addr);
      if (wvalid && wready)   chk("w_data", wdata, cur.wdata);
      if (arvalid && arready) chk("ar_addr", araddr, cur.addr);
      if (bvalid && bready) n_b_hs++;
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got resp %0h with no command pending", rsp_resp);
        end else begin
          e = q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", rsp_resp, e.resp);
        end
        last_rdata = rsp_rdata; last_resp = rsp_resp;
        last_rv_cyc = rv_cyc; t_rsp_hs = cyc; outstanding = 0;
      end
      if (cmd_valid && cmd_ready) begin
        n.write = cmd_write; n.addr = cmd_addr; n.wdata = cmd_wdata;
        n.to    = TO_EN && (cmd_write ? cfg_b_never : cfg_ar_never);
        n.rdata = (cmd_write || n.to) ? '0 : cfg_rdata;
        n.resp  = n.to ? 2'b11 : (cmd_write ? cfg_bresp : cfg_rresp);
        q.push_back(n); cur = n; outstanding = 1; t_accept = cyc;
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0; rv_cyc = 0;
      end
      p_aw = awvalid; p_awr = awready; p_w = wvalid; p_wr = wready;
      p_ar = arvalid; p_arr = arready; p_rv = rsp_valid; p_rr = rsp_ready;
      p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata;
      p_rdata = rsp_rdata; p_resp = rsp_resp;
    end
  end

  // Driver tasks start and end just after a rising edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    if (!acc) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit hs = 0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk); hs = rsp_valid && rsp_ready;
      @(posedge clk); #1;
    end
    if (!hs) chk("rsp_wait_timeout", 0, 1);
  endtask

  initial begin : main
    int b0, rv;
    bit seen;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 0;
    @(posedge clk); #1;

    // 1: zero-wait read
    cfg_rdata = 32'h01E0_0280; cfg_rresp = 2'b00;
    issue(0, 32'h008, '0);
    wait_done();
    chk("t1_ar_latency", t_ar_rise - t_accept, 1);
    chk("t1_rsp_latency", t_rsp_rise - t_accept, 3);
    chk("t1_rdata", last_rdata, 32'h01E0_0280);
    chk("t1_resp", last_resp, 2'b00);

    // 2: write with AW ready delayed 3 cycles
    cfg_aw_delay = 3; cfg_bresp = 2'b00; b0 = n_b_hs;
    issue(1, 32'h104, 32'h000A_000A);
    wait_done();
    chk("t2_wvalid_cycles", w_cyc, 1);
    chk("t2_awvalid_cycles", aw_cyc, 4);
    chk("t2_b_handshakes", n_b_hs - b0, 1);
    chk("t2_rsp_latency", t_rsp_rise - t_accept, 6);
    chk("t2_resp_rdata", {last_rdata, last_resp}, 34'd0);
    cfg_aw_delay = 0;

    // 3: read with SLVERR
    cfg_rdata = 32'hFFFF_FFFF; cfg_rresp = 2'b10;
    issue(0, 32'h00C, '0);
    chk("t3_cmd_ready_busy", cmd_ready, 0);
    wait_done();
    chk("t3_resp", last_resp, 2'b10);
    chk("t3_rdata", last_rdata, 32'hFFFF_FFFF);

    // 4: response back-pressure then back-to-back command
    rsp_ready = 0; seen = 0;
    issue(1, 32'h10C, 32'h0000_1234);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); seen = rsp_valid;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("t4_rsp_seen", seen, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_held", {rsp_valid, cmd_ready}, 2'b10);
    cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00; rsp_ready = 1;
    issue(0, 32'h008, '0);
    chk("t4_rsp_valid_cycles", last_rv_cyc, 6);
    chk("t4_b2b_gap", t_accept - t_rsp_hs, 1);
    wait_done();
    chk("t4_rdata", last_rdata, 32'hCAFE_F00D);

    // 5: reset while waiting for B
    cfg_b_never = 1; seen = 0;
    issue(1, 32'h100, 32'h55);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); seen = bready;
      if (!seen) begin @(posedge clk); #1; end
    end
    chk("t5_in_wr_resp", seen, 1);
    #2 rst = 1;
    #1 chk("t5_async_clear", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy, cmd_ready}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 0; cfg_b_never = 0;
    rv = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) rv++; end
    chk("t5_no_rsp", rv, 0);
    chk("t5_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // Write with SLVERR passes through unchanged
    cfg_bresp = 2'b10;
    issue(1, 32'h000, 32'h1);
    wait_done();
    chk("wr_slverr", {last_rdata, last_resp}, {32'd0, 2'b10});
    cfg_bresp = 2'b00;

`ifdef AXI_MASTER_TIMEOUT_EN
    // 6: slave never takes AR
    cfg_ar_never = 1;
    issue(0, 32'h010, '0);
    wait_done();
    chk("t6_arvalid_cycles", ar_cyc, 16);
    chk("t6_resp", {last_rdata, last_resp}, {32'd0, 2'b11});
    chk("t6_flag", timeout_flag, 1);
    cfg_ar_never = 0;
    repeat (3) @(posedge clk);
    #1 chk("t6_flag_sticky", timeout_flag, 1);
    @(negedge clk); #2 rst = 1;
    #1 chk("t6_flag_reset", timeout_flag, 0);
    @(negedge clk); #2 rst = 0;
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
